mapa: RTL and testbench

Block-grid map store feeding the renderer. Holds one 2-bit cell type per 8×8 screen block, returns a palette colour for the block the renderer requests one cycle later, and gives game logic a read-before-write port for moving the snake and checking collisions. After reset or `clear` it sweeps the grid to a bordered empty arena before accepting game traffic.

---
 rtl/mapa_pkg.sv | 54 +++++
 rtl/mapa_if.sv | 31 +++
 rtl/mapa_ram.sv | 32 +++
 rtl/mapa.sv | 144 ++++++++++++++
 tb/tb_mapa.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mapa_pkg.sv
// Shared constants for the block-grid map: grid geometry, cell types, palette and address helpers.
// Imported by the map store, the renderer and the game logic.
package mapa_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int BLOCK_BITS    = 3;
    localparam int BLOCK_SIZE    = 1 << BLOCK_BITS;
    localparam int GW            = SCREEN_WIDTH / BLOCK_SIZE;
    localparam int GH            = SCREEN_HEIGHT / BLOCK_SIZE;
    localparam int CELLS         = GW * GH;
    localparam int ADDR_W        = $clog2(CELLS);
    localparam int GX_W          = 7;
    localparam int GY_W          = 6;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WALL  = 2'd1,
        SNAKE = 2'd2,
        FOOD  = 2'd3
    } cell_t;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t RGB_EMPTY = '{r: 2'd0, g: 2'd0, b: 2'd0};
    localparam rgb_t RGB_WALL  = '{r: 2'd2, g: 2'd2, b: 2'd2};
    localparam rgb_t RGB_SNAKE = '{r: 2'd0, g: 2'd3, b: 2'd0};
    localparam rgb_t RGB_FOOD  = '{r: 2'd3, g: 2'd0, b: 2'd0};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic addr_t cell_addr(logic [GX_W-1:0] x, logic [GY_W-1:0] y);
        return addr_t'(y) * addr_t'(GW) + addr_t'(x);
    endfunction

    function automatic rgb_t palette(cell_t c);
        case (c)
            WALL:    return RGB_WALL;
            SNAKE:   return RGB_SNAKE;
            FOOD:    return RGB_FOOD;
            default: return RGB_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/mapa_if.sv
// Renderer and game-logic signals of the map store.
// master = renderer/game side, slave = map store.
interface mapa_if;
    import mapa_pkg::*;

    logic [9:0]      mapa_x;
    logic [9:0]      mapa_y;
    logic            mapa_read;
    logic [1:0]      mapa_R;
    logic [1:0]      mapa_G;
    logic [1:0]      mapa_B;

    logic            game_en;
    logic            game_we;
    logic [GX_W-1:0] game_x;
    logic [GY_W-1:0] game_y;
    logic [1:0]      game_wdata;
    logic [1:0]      game_rdata;
    logic            game_valid;

    modport master (
        output mapa_x, mapa_y, mapa_read, game_en, game_we, game_x, game_y, game_wdata,
        input  mapa_R, mapa_G, mapa_B, game_rdata, game_valid
    );

    modport slave (
        input  mapa_x, mapa_y, mapa_read, game_en, game_we, game_x, game_y, game_wdata,
        output mapa_R, mapa_G, mapa_B, game_rdata, game_valid
    );

endinterface

// File: rtl/mapa_ram.sv
// Simple dual-port 4800x2 map RAM: port A write with read-old, port B read-only.
// Both read ports are registered so the array maps onto a block RAM.
module mapa_ram
    import mapa_pkg::*;
(
    input  logic       clk,
    input  logic       en_a,
    input  logic       we_a,
    input  addr_t      addr_a,
    input  logic [1:0] wdata_a,
    output logic [1:0] rdata_a,
    input  addr_t      addr_b,
    output logic [1:0] rdata_b
);

    // NOTE: the array has no reset; its contents are defined by the clear sweep.
    logic [1:0] mem [CELLS];

    always_ff @(posedge clk) begin
        if (en_a) begin
            rdata_a <= mem[addr_a];
            if (we_a) begin
                mem[addr_a] <= wdata_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/mapa.sv
// Block-grid map store: arena-initialising sweep, read-before-write game port,
// and a one-cycle renderer colour lookup.
module mapa
    import mapa_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   clear,
    output logic   busy,
    mapa_if.slave  bus
);

    state_t          state;
    state_t          state_next;
    addr_t           clr_addr;
    logic [GX_W-1:0] clr_x;
    logic [GY_W-1:0] clr_y;
    logic            clr_restart;
    logic            clr_last;
    logic            clr_border;

    logic            ram_en_a;
    logic            ram_we_a;
    addr_t           ram_addr_a;
    logic [1:0]      ram_wdata_a;
    logic [1:0]      ram_rdata_a;
    addr_t           ram_addr_b;
    logic [1:0]      ram_rdata_b;

    logic            game_oob;
    logic            game_valid_q;
    logic            game_oob_q;
    logic            rend_in;
    logic            rend_q;
    rgb_t            colour;

    assign clr_last   = (clr_addr == addr_t'(CELLS - 1));
    assign clr_border = (clr_x == '0) || (int'(clr_x) == GW - 1) ||
                        (clr_y == '0) || (int'(clr_y) == GH - 1);

    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        clr_restart = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (clear) begin
                    clr_restart = 1'b1;
                end else if (clr_last) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (clear) begin
                    state_next  = ST_CLEAR;
                    clr_restart = 1'b1;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // x/y track the sweep address so the border test needs no divider.
    always_ff @(posedge clk) begin
        if (reset || clr_restart) begin
            clr_addr <= '0;
            clr_x    <= '0;
            clr_y    <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (int'(clr_x) == GW - 1) begin
                clr_x <= '0;
                clr_y <= clr_y + 1'b1;
            end else begin
                clr_x <= clr_x + 1'b1;
            end
        end
    end

    assign game_oob = (int'(bus.game_x) >= GW) || (int'(bus.game_y) >= GH);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ram_en_a    = 1'b0;
        ram_we_a    = 1'b0;
        ram_addr_a  = '0;
        ram_wdata_a = EMPTY;
        if (state == ST_CLEAR) begin
            ram_en_a    = 1'b1;
            ram_we_a    = 1'b1;
            ram_addr_a  = clr_addr;
            ram_wdata_a = clr_border ? WALL : EMPTY;
        end else if (bus.game_en && !game_oob) begin
            ram_en_a    = 1'b1;
            ram_we_a    = bus.game_we;
            ram_addr_a  = cell_addr(bus.game_x, bus.game_y);
            ram_wdata_a = bus.game_wdata;
        end
    end

    assign rend_in    = (int'(bus.mapa_x) < GW) && (int'(bus.mapa_y) < GH);
    assign ram_addr_b = rend_in ? cell_addr(bus.mapa_x[GX_W-1:0], bus.mapa_y[GY_W-1:0]) : '0;

    mapa_ram u_ram (
        .clk     (clk),
        .en_a    (ram_en_a),
        .we_a    (ram_we_a),
        .addr_a  (ram_addr_a),
        .wdata_a (ram_wdata_a),
        .rdata_a (ram_rdata_a),
        .addr_b  (ram_addr_b),
        .rdata_b (ram_rdata_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            game_valid_q <= 1'b0;
            game_oob_q   <= 1'b0;
            rend_q       <= 1'b0;
        end else begin
            game_valid_q <= (state == ST_READY) && bus.game_en;
            game_oob_q   <= game_oob;
            rend_q       <= bus.mapa_read && rend_in;
        end
    end

    // Off-grid game accesses report WALL so leaving the arena reads as a collision.
    assign busy           = (state == ST_CLEAR);
    assign bus.game_valid = game_valid_q;
    assign bus.game_rdata = !game_valid_q ? EMPTY : (game_oob_q ? WALL : ram_rdata_a);
    assign colour         = rend_q ? palette(cell_t'(ram_rdata_b)) : RGB_EMPTY;
    assign bus.mapa_R     = colour.r;
    assign bus.mapa_G     = colour.g;
    assign bus.mapa_B     = colour.b;

endmodule

// File: tb/tb_mapa.sv
// Scoreboard bench for mapa: drivers push expected responses, a negedge monitor
// pops and compares whenever game_valid or a renderer response is due.
module tb_mapa;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic busy;

    mapa_if bus ();

    mapa dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] C_BLACK = 6'b00_00_00;
    localparam logic [5:0] C_WALL  = 6'b10_10_10;
    localparam logic [5:0] C_SNAKE = 6'b00_11_00;
    localparam logic [5:0] C_FOOD  = 6'b11_00_00;
    localparam logic [1:0] T_EMPTY = 2'd0;
    localparam logic [1:0] T_WALL  = 2'd1;
    localparam logic [1:0] T_SNAKE = 2'd2;
    localparam logic [1:0] T_FOOD  = 2'd3;

    int checks   = 0;
    int failures = 0;

    logic [1:0] game_q [$];
    logic [5:0] rend_q [$];
    logic       rend_req  = 1'b0;
    logic       rend_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rend_pend <= rend_req;

    always @(negedge clk) begin
        if (bus.game_valid) begin
            if (game_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL game_valid_unexpected: got valid with rdata %0h, expected no response at %0t",
                         bus.game_rdata, $time);
            end else begin
                check("game_rdata", 32'(bus.game_rdata), 32'(game_q.pop_front()));
            end
        end
        if (rend_pend) begin
            if (rend_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL colour_unexpected: response due but nothing queued at %0t", $time);
            end else begin
                check("colour", 32'({bus.mapa_R, bus.mapa_G, bus.mapa_B}), 32'(rend_q.pop_front()));
            end
        end
    end

    task automatic set_game(input int x, input int y, input logic we, input logic [1:0] wd,
                            input logic expect_resp, input logic [1:0] exp);
        bus.game_en    = 1'b1;
        bus.game_we    = we;
        bus.game_x     = 7'(x);
        bus.game_y     = 6'(y);
        bus.game_wdata = wd;
        if (expect_resp) game_q.push_back(exp);
    endtask

    task automatic set_render(input int x, input int y, input logic rd, input logic [5:0] exp);
        bus.mapa_x    = 10'(x);
        bus.mapa_y    = 10'(y);
        bus.mapa_read = rd;
        rend_req      = 1'b1;
        rend_q.push_back(exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.game_en   = 1'b0;
        bus.game_we   = 1'b0;
        bus.mapa_read = 1'b0;
        rend_req      = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int exp_cycles);
        int n = 0;
        while (busy && n < 6000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        bus.mapa_x     = '0;
        bus.mapa_y     = '0;
        bus.mapa_read  = 1'b0;
        bus.game_en    = 1'b0;
        bus.game_we    = 1'b0;
        bus.game_x     = '0;
        bus.game_y     = '0;
        bus.game_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("busy_reset", 32'(busy), 32'd1);
        check("rgb_reset", 32'({bus.mapa_R, bus.mapa_G, bus.mapa_B}), 32'(C_BLACK));
        check("game_valid_reset", 32'(bus.game_valid), 32'd0);
        check("game_rdata_reset", 32'(bus.game_rdata), 32'd0);
        reset = 1'b0;
        wait_ready("sweep_after_reset", 4800);

        // Arena contents after the sweep, including row-wrap border cells.
        set_render(0, 0, 1'b1, C_WALL);   step();
        set_render(5, 5, 1'b1, C_BLACK);  step();
        set_render(79, 59, 1'b1, C_WALL); step();
        set_render(79, 1, 1'b1, C_WALL);  step();
        set_render(0, 2, 1'b1, C_WALL);   step();
        set_render(78, 58, 1'b1, C_BLACK); step();
        set_game(1, 1, 1'b0, T_EMPTY, 1'b1, T_EMPTY); step();
        set_game(79, 5, 1'b0, T_EMPTY, 1'b1, T_WALL); step();
        set_game(0, 59, 1'b0, T_EMPTY, 1'b1, T_WALL); step();

        // Read-before-write, back to back.
        set_game(10, 20, 1'b1, T_SNAKE, 1'b1, T_EMPTY); step();
        set_render(10, 20, 1'b1, C_SNAKE); step();
        set_game(10, 20, 1'b1, T_FOOD, 1'b1, T_SNAKE); step();
        set_game(10, 20, 1'b0, T_EMPTY, 1'b1, T_FOOD); step();

        // Same-cell write and render read in one cycle: render sees the old cell.
        set_game(10, 20, 1'b1, T_WALL, 1'b1, T_FOOD);
        set_render(10, 20, 1'b1, C_FOOD);
        step();
        set_render(10, 20, 1'b1, C_WALL); step();

        // Off-grid accesses: WALL, no write (address 320 would alias cell (0,4)).
        set_game(80, 3, 1'b1, T_SNAKE, 1'b1, T_WALL); step();
        set_game(3, 60, 1'b1, T_SNAKE, 1'b1, T_WALL); step();
        set_render(0, 4, 1'b1, C_WALL);   step();
        set_render(80, 3, 1'b1, C_BLACK); step();
        set_render(5, 0, 1'b0, C_BLACK);  step();
        set_render(3, 60, 1'b1, C_BLACK); step();

        // Clear restores the arena; game traffic during the sweep is dropped.
        set_game(30, 30, 1'b1, T_SNAKE, 1'b1, T_EMPTY); step();
        set_game(1, 1, 1'b1, T_SNAKE, 1'b1, T_EMPTY);   step();
        set_render(30, 30, 1'b1, C_SNAKE); step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("busy_after_clear", 32'(busy), 32'd1);
        set_game(40, 40, 1'b1, T_SNAKE, 1'b0, T_EMPTY);
        set_render(30, 30, 1'b1, C_SNAKE);
        step();
        wait_ready("sweep_after_clear", 4799);
        set_render(30, 30, 1'b1, C_BLACK); step();
        set_render(40, 40, 1'b1, C_BLACK); step();
        set_render(0, 0, 1'b1, C_WALL);    step();
        set_game(1, 1, 1'b0, T_EMPTY, 1'b1, T_EMPTY); step();

        // Clear in the middle of a sweep restarts it.
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (1000) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        wait_ready("sweep_clear_restart", 4800);

        // Reset at sweep address 2000 restarts it.
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (2000) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("busy_after_mid_reset", 32'(busy), 32'd1);
        wait_ready("sweep_after_mid_reset", 4800);
        set_render(0, 0, 1'b1, C_WALL);  step();
        set_render(5, 5, 1'b1, C_BLACK); step();

        repeat (2) step();
        check("game_q_drained", 32'(game_q.size()), 32'd0);
        check("rend_q_drained", 32'(rend_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
